csel_addsub_pipe: RTL

- Parametrised, pipelined carry-select adder/subtractor. It replaces fixed-width 16-bit combinational carry-select adders on datapaths that need wider operands, subtraction, flags and flow control.
- The operand is split into BLOCK-bit groups. Each group is computed for carry-in 0 and carry-in 1, and the real carry selects the result.
- Groups are spread across STAGES register stages, with valid/ready handshakes at input and output.

---
 rtl/csel_addsub_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/csel_addsub_pipe.sv
// Pipelined carry-select adder/subtractor: BLOCK-bit groups resolved GPS at a time
// per stage, with bubble-collapsing valid/ready flow control and result flags.
`timescale 1ns/1ps
module csel_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int GPS  = NBLK / STAGES;
  localparam int MSB  = WIDTH - 1;

  // One carry-select group: both carry-in hypotheses rippled, real carry picks.
  function automatic logic [BLOCK:0] csel_group(input logic [BLOCK-1:0] a,
                                                input logic [BLOCK-1:0] b,
                                                input logic             cin);
    logic [BLOCK-1:0] s0, s1;
    logic             c0, c1;
    c0 = 1'b0;
    c1 = 1'b1;
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s0[i] = a[i] ^ b[i] ^ c0;
      c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
      s1[i] = a[i] ^ b[i] ^ c1;
      c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
    end
    return {c0 | (cin & c1), cin ? s1 : s0};
  endfunction

  logic [STAGES-1:0] vld_p, adv, ld;
  logic [STAGES:0]   rdy;
  logic [STAGES:0]   vchain;

  logic [WIDTH-1:0]  a_p   [STAGES];
  logic [WIDTH-1:0]  bx_p  [STAGES];
  logic [WIDTH-1:0]  sum_p [STAGES];
  logic [STAGES-1:0] cy_p;

  logic [WIDTH-1:0]  a_nx   [STAGES];
  logic [WIDTH-1:0]  bx_nx  [STAGES];
  logic [WIDTH-1:0]  sum_nx [STAGES];
  logic [STAGES-1:0] cy_nx;
  logic              ovf_nx;

  assign vchain    = {vld_p, in_valid};
  assign in_ready  = rdy[0];
  assign out_valid = vld_p[STAGES-1];

  // Ready ripples back from the consumer; a stage loads when empty or draining.
  always_comb begin
    rdy         = '0;
    adv         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = vld_p[k] & rdy[k+1];
      rdy[k] = ~vld_p[k] | adv[k];
    end
    ld = rdy[STAGES-1:0] & vchain[STAGES-1:0];
  end

  // Per-stage resolution of this stage's groups from the registered carry.
  always_comb begin
    logic             cg;
    logic [BLOCK:0]   rg;
    int               j;
    int               base;
    cg    = 1'b0;
    rg    = '0;
    cy_nx = '0;
    for (int k = 0; k < STAGES; k++) begin
      j = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        a_nx[k]   = A;
        bx_nx[k]  = Sub ? ~B : B;
        sum_nx[k] = '0;
        cg        = Sub ? ~Cin : Cin;
      end else begin
        a_nx[k]   = a_p[j];
        bx_nx[k]  = bx_p[j];
        sum_nx[k] = sum_p[j];
        cg        = cy_p[j];
      end
      for (int g = 0; g < GPS; g++) begin
        base = (k * GPS + g) * BLOCK;
        rg   = csel_group(a_nx[k][base +: BLOCK], bx_nx[k][base +: BLOCK], cg);
        sum_nx[k][base +: BLOCK] = rg[BLOCK-1:0];
        cg   = rg[BLOCK];
      end
      cy_nx[k] = cg;
    end
    ovf_nx = (a_nx[STAGES-1][MSB] == bx_nx[STAGES-1][MSB]) &
             (sum_nx[STAGES-1][MSB] != a_nx[STAGES-1][MSB]);
  end

  // Inter-stage operand/partial-sum registers
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (ld[k]) begin
        a_p[k]   <= a_nx[k];
        bx_p[k]  <= bx_nx[k];
        sum_p[k] <= sum_nx[k];
        cy_p[k]  <= cy_nx[k];
      end
    end
  end

  // Stage valids and the final-stage result/flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
      Zero  <= 1'b0;
    end else begin
      vld_p <= ld | (vld_p & ~adv);
      if (ld[STAGES-1]) begin
        Sum  <= sum_nx[STAGES-1];
        Cout <= cy_nx[STAGES-1];
        Ovf  <= ovf_nx;
        Zero <= ~|sum_nx[STAGES-1];
      end
    end
  end

endmodule
